// File: rtl/puf_pkg.sv
// puf_pkg: shared state encoding, width helpers and reset defaults for the PUF response collector
package puf_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_SEED, S_WAIT_SEED, S_STEP, S_SETTLE, S_SAMPLE, S_COMMIT, S_DONE
  } state_t;
  localparam logic RST_BIT = 1'b0;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int resp_width(input int word_w, input int num_words);
    return word_w * num_words;
  endfunction
endpackage

// File: rtl/puf_bit_vote.sv
// puf_bit_vote: per-bit sample counters producing the majority word and the unstable-bit count
module puf_bit_vote
  import puf_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int VOTES = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          acc,
  input  logic [WORD_W-1:0]             d,
  output logic [WORD_W-1:0]             maj,
  output logic [clog2(WORD_W+1)-1:0]    pop
);
  localparam int VW = clog2(VOTES + 1);
  localparam int PW = clog2(WORD_W + 1);
  logic [VW-1:0] cnt [WORD_W];
  always_ff @(posedge clk)
    for (int i = 0; i < WORD_W; i++)
      if (rst || clr) cnt[i] <= '0;
      else if (acc) cnt[i] <= cnt[i] + VW'(d[i]);
  always_comb begin
    maj = '0;
    pop = '0;
    for (int i = 0; i < WORD_W; i++) begin
      maj[i] = cnt[i] > VW'(VOTES / 2);
      pop = pop + PW'(cnt[i] != '0 && cnt[i] != VW'(VOTES));
    end
  end
endmodule

// File: rtl/puf_resp_collector.sv
// puf_resp_collector: seeds the challenge LFSR, majority-votes PUF samples per word and packs the response
module puf_resp_collector
  import puf_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int NUM_WORDS = 8,
  parameter int VOTES = 3,
  parameter int SETTLE = 2,
  parameter int TIMEOUT = 255,
  parameter logic [WORD_W*NUM_WORDS-1:0] RST_VAL = {(WORD_W*NUM_WORDS){RST_BIT}}
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [WORD_W-1:0]                      challenge,
  output logic                                   lfsr_load,
  output logic [WORD_W-1:0]                      lfsr_seed,
  input  logic                                   lfsr_ready,
  output logic                                   lfsr_next,
  input  logic [WORD_W-1:0]                      puf_word,
  output logic [WORD_W*NUM_WORDS-1:0]            resp,
  output logic [clog2(WORD_W*NUM_WORDS+1)-1:0]   unstable_cnt,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   err
);
  localparam int RESP_W = resp_width(WORD_W, NUM_WORDS);
  localparam int UW = clog2(RESP_W + 1);
  localparam int VW = clog2(VOTES + 1);
  localparam int PW = clog2(WORD_W + 1);
  localparam int IW = NUM_WORDS > 1 ? clog2(NUM_WORDS) : 1;
  localparam int TW = clog2(TIMEOUT + 1);
  localparam int SW = clog2(SETTLE + 1);
  state_t state;
  logic [VW-1:0] vote_idx;
  logic [IW-1:0] word_idx;
  logic [TW-1:0] tcnt;
  logic [SW-1:0] scnt;
  logic [WORD_W-1:0] maj;
  logic [PW-1:0] pop;
  logic [UW:0] usum;
  assign usum = (UW+1)'(unstable_cnt) + (UW+1)'(pop);
  puf_bit_vote #(.WORD_W(WORD_W), .VOTES(VOTES)) u_vote (
    .clk(clk),
    .rst(rst),
    .clr(state == S_COMMIT),
    .acc(state == S_SAMPLE),
    .d(puf_word),
    .maj(maj),
    .pop(pop)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      resp <= RST_VAL;
      unstable_cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      lfsr_load <= 1'b0;
      lfsr_next <= 1'b0;
      lfsr_seed <= '0;
      vote_idx <= '0;
      word_idx <= '0;
      tcnt <= '0;
      scnt <= '0;
    end else begin
      lfsr_load <= 1'b0;
      lfsr_next <= 1'b0;
      case (state)
        S_IDLE, S_DONE: if (start) begin
          lfsr_seed <= challenge;
          resp <= RST_VAL;
          unstable_cnt <= '0;
          err <= 1'b0;
          done <= 1'b0;
          busy <= 1'b1;
          vote_idx <= '0;
          word_idx <= '0;
          tcnt <= '0;
          lfsr_load <= 1'b1;
          state <= S_SEED;
        end
        S_SEED: state <= S_WAIT_SEED;
        S_WAIT_SEED: if (lfsr_ready) begin
          lfsr_next <= 1'b1;
          state <= S_STEP;
        end else if (tcnt == TW'(TIMEOUT)) begin
          resp <= RST_VAL;
          err <= 1'b1;
          done <= 1'b1;
          busy <= 1'b0;
          state <= S_DONE;
        end else tcnt <= tcnt + TW'(1);
        S_STEP: begin
          scnt <= '0;
          state <= S_SETTLE;
        end
        S_SETTLE: if (scnt == SW'(SETTLE - 1)) state <= S_SAMPLE;
        else scnt <= scnt + SW'(1);
        S_SAMPLE: begin
          vote_idx <= vote_idx + VW'(1);
          if (vote_idx == VW'(VOTES - 1)) state <= S_COMMIT;
          else begin
            lfsr_next <= 1'b1;
            state <= S_STEP;
          end
        end
        S_COMMIT: begin
          resp[RESP_W-1-int'(word_idx)*WORD_W -: WORD_W] <= maj;
          unstable_cnt <= usum > (UW+1)'(RESP_W) ? UW'(RESP_W) : usum[UW-1:0];
          vote_idx <= '0;
          if (word_idx == IW'(NUM_WORDS - 1)) begin
            done <= 1'b1;
            busy <= 1'b0;
            state <= S_DONE;
          end else begin
            word_idx <= word_idx + IW'(1);
            lfsr_next <= 1'b1;
            state <= S_STEP;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_puf_resp_collector.sv
// tb_puf_resp_collector: directed checks of the PUF response collector in default and small configurations
module tb_puf_resp_collector;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, lfsr_ready = 1'b1;
  logic [15:0] challenge = '0, puf_word = 16'hA5A5;
  logic lfsr_load, lfsr_next, busy, done, err;
  logic [15:0] lfsr_seed;
  logic [127:0] resp;
  logic [7:0] unstable_cnt;
  logic start_b = 1'b0, load_b, next_b, busy_b, done_b, err_b;
  logic [15:0] seed_b, puf_b = '0;
  logic [31:0] resp_b;
  logic [5:0] ucnt_b;
  int checks = 0, errors = 0;
  int mode = 0, steps = 0, steps_b = 0, nexts = 0, loads = 0, overlaps = 0;
  always #5 clk = ~clk;
  puf_resp_collector dut (
    .clk(clk), .rst(rst), .start(start), .challenge(challenge),
    .lfsr_load(lfsr_load), .lfsr_seed(lfsr_seed), .lfsr_ready(lfsr_ready),
    .lfsr_next(lfsr_next), .puf_word(puf_word), .resp(resp),
    .unstable_cnt(unstable_cnt), .busy(busy), .done(done), .err(err)
  );
  puf_resp_collector #(.NUM_WORDS(2), .VOTES(1), .SETTLE(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .challenge(16'h00AA),
    .lfsr_load(load_b), .lfsr_seed(seed_b), .lfsr_ready(1'b1),
    .lfsr_next(next_b), .puf_word(puf_b), .resp(resp_b),
    .unstable_cnt(ucnt_b), .busy(busy_b), .done(done_b), .err(err_b)
  );
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic pulse_start(input logic [15:0] ch);
    @(negedge clk);
    start = 1'b1;
    challenge = ch;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic run(input int restart_at, output int n);
    n = 0;
    while (!done && n < 2000) begin
      start = (n + 1 == restart_at);
      @(posedge clk);
      #1 n++;
    end
    start = 1'b0;
  endtask
  initial forever begin
    @(negedge clk);
    if (lfsr_load) loads++;
    if ((lfsr_load && lfsr_next) || (load_b && next_b)) overlaps++;
    if (lfsr_next) begin
      nexts++;
      puf_word = mode == 1 ? ((steps % 3 == 1) ? 16'h1235 : 16'h1234) : 16'hA5A5;
      steps++;
    end
    if (next_b) begin
      steps_b++;
      puf_b = 16'(steps_b);
    end
  end
  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_resp", resp, '0);
    check("rst_flags", {busy, done, err, lfsr_load, lfsr_next}, 5'b0);
    check("rst_ucnt", unstable_cnt, 8'd0);
    check("rst_seed", lfsr_seed, 16'h0);
    rst = 1'b0;
    pulse_start(16'h1111);
    check("busy_after_start", busy, 1'b1);
    run(0, n);
    check("const_latency", n, 106);
    check("const_resp", resp, {8{16'hA5A5}});
    check("const_ucnt", unstable_cnt, 8'd0);
    check("const_err_busy", {err, busy}, 2'b00);
    check("const_nexts", nexts, 24);
    check("const_loads", loads, 1);
    check("const_seed", lfsr_seed, 16'h1111);
    mode = 1;
    steps = 0;
    pulse_start(16'hBEEF);
    check("restart_seed", lfsr_seed, 16'hBEEF);
    check("restart_done_drop", {done, busy}, 2'b01);
    check("restart_resp_clear", resp, '0);
    challenge = 16'h5555;
    run(40, n);
    check("vote_latency", n, 106);
    check("vote_resp", resp, {8{16'h1234}});
    check("vote_ucnt", unstable_cnt, 8'd8);
    check("vote_seed_held", lfsr_seed, 16'hBEEF);
    mode = 0;
    lfsr_ready = 1'b0;
    nexts = 0;
    pulse_start(16'h0F0F);
    run(0, n);
    check("tmo_latency", n, 257);
    check("tmo_flags", {done, err, busy}, 3'b110);
    check("tmo_resp", resp, '0);
    check("tmo_nexts", nexts, 0);
    lfsr_ready = 1'b1;
    pulse_start(16'h2222);
    repeat (59) @(posedge clk);
    #1 check("mid_busy", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_resp", resp, '0);
    check("abort_flags", {busy, done, err, lfsr_load, lfsr_next}, 5'b0);
    check("abort_ucnt_seed", {unstable_cnt, lfsr_seed}, 24'h0);
    rst = 1'b0;
    pulse_start(16'h3333);
    run(0, n);
    check("fresh_latency", n, 106);
    check("fresh_resp", resp, {8{16'hA5A5}});
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
    n = 0;
    while (!done_b && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    check("small_latency", n, 10);
    check("small_resp", resp_b, 32'h00010002);
    check("small_ucnt_err", {ucnt_b, err_b, busy_b}, 8'h0);
    check("small_seed", seed_b, 16'h00AA);
    check("strobe_overlap", overlaps, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
